filter_buffer_ctrl: RTL and testbench
=====================================

# filter_buffer_ctrl

Sequencer for the CNN filter buffer. On `start` it fetches four 32-bit filter words from filter memory, writes them into the 128-bit filter buffer, then replays the 16 filter bytes once per convolution window to the downstream MAC, with per-byte backpressure. It sits between the filter memory, the filter buffer and the MAC/PE pipeline, and drives all of the buffer's control strobes.

## Interface
- `ADDR_W`, 8: filter memory address width.
- `WIN_W`, 8: width of the window count.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `start  in  1`: begin a load-and-stream job; ignored while `busy`.
- `filtBaseAddr  in  ADDR_W`: first filter word address; latched on an accepted `start`.
- `numWindows  in  WIN_W`: number of stream passes; latched on an accepted `start`.
- `memRdEn  out  1`: one-cycle read request.
- `memRdAddr  out  ADDR_W`: read address, equal to base + word index.
- `memRdData  in  32`: read data.
- `memRdValid  in  1`: read data valid; latency ≥1 cycle, exactly one response per request.
- `filterIn  out  32`: word to the buffer.
- `WEFilter  out  1`: buffer write enable.
- `REFilter  out  1`: buffer read/shift enable.
- `rstFilter  out  1`: resets the buffer's shift counter.
- `macReady  in  1`: downstream can accept a byte.
- `byteValid  out  1`: buffer `filterOut` holds a valid byte this cycle.
- `lastByte  out  1`: qualifies the 16th byte of a pass.
- `windowDone  out  1`: one-cycle pulse at the end of each pass.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse when the job ends.

## Operation
- States: IDLE, FETCH, WAITRD, WRITE, ARM, STREAM, DONE.
- IDLE → FETCH on `start`. Latch base address and `numWindows`; clear `wordCnt` (2 bit) and `winCnt` (WIN_W).
- FETCH:
  - `memRdEn`=1 for one cycle, `memRdAddr`=base+`wordCnt` (modulo 2^ADDR_W).
  - Next state is WAITRD.
- WAITRD: hold until `memRdValid`, then capture `memRdData` into `filterIn` and go to WRITE.
- WRITE:
  - `WEFilter`=1 for one cycle.
  - If `wordCnt`==3: go to ARM, or to DONE when `numWindows`==0.
  - Otherwise increment `wordCnt` and go to FETCH.
- Load completion comes only from the internal `wordCnt`; the controller does not depend on any buffer status flag.
- ARM: `rstFilter`=1 for one cycle with `REFilter`=0. Clear `byteCnt` (4 bit). Next state is STREAM.
- STREAM:
  - `REFilter` = `macReady`, combinationally gated by state.
  - `byteCnt` increments on each cycle with `REFilter`=1.
  - When `REFilter`=1 and `byteCnt`==15: increment `winCnt`. Go to DONE if `winCnt`+1==`numWindows`, else to ARM.
- DONE: `done`=1 for one cycle, then IDLE.
- Byte order: word 0 bits [31:24] come out first and word 3 bits [7:0] come out last.
- Mutual exclusion: `WEFilter`, `REFilter` and `rstFilter` are never high in the same cycle.
- `memRdValid` outside WAITRD is ignored.
- `start` while `busy` is ignored with no side effects.
- `rst` mid-operation: immediately returns to IDLE and clears all counters. The buffer contents are then stale, and the next job reloads them.

## Timing
- Reset value of every output is 0, including `memRdAddr` and `filterIn`.
- Buffer output is registered, so `byteValid` is `REFilter` delayed one cycle. `lastByte` is the registered `REFilter && byteCnt==15`. `windowDone` equals `lastByte`.
- Load cost is 3 cycles per word with 1-cycle memory latency, so 12 cycles for 4 words.
- Pass cost with `macReady` held high is 1 ARM cycle + 16 STREAM cycles = 17 cycles.
- A low `macReady` stalls STREAM with no byte lost or duplicated.
- End-to-end with `numWindows`=N, 1-cycle memory and no stalls: `done` is 1+12+17N cycles after the `start` edge.

## Configuration
- `FILTER_STALL_CNT_EN`, when defined:
  - Adds output `stallCount` (16 bits), which counts cycles spent in STREAM with `macReady`=0.
  - Saturates at 16'hFFFF.
  - Clears on an accepted `start` and on `rst`.
- When undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Base load: base=8'h10, memory words {A1A2A3A4, B1B2B3B4, C1C2C3C4, D1D2D3D4}, N=1, `macReady`=1.
  - Reads at 10..13, four `WEFilter` pulses.
  - Byte stream is A1,A2,…,D4 with `lastByte` on D4.
  - `done` 30 cycles after `start`.
- Multi-window: N=3. Three identical 16-byte passes, `rstFilter` before each pass, three `windowDone` pulses, then a single `done`.
- Backpressure: `macReady` low for 5 cycles after byte 7.
  - Still exactly 16 bytes in order.
  - `stallCount`=5 when FILTER_STALL_CNT_EN is defined.
- Edge values: N=0 gives a load only, no `REFilter`, and `done` right after the fourth write. Base=8'hFE gives reads at FE, FF, 00, 01.
- Reset mid-STREAM at byte 9:
  - All outputs go to 0 immediately and the FSM is in IDLE.
  - A new `start` performs a full reload and a correct stream.
- Variable memory latency: latency of 3 cycles, plus `start` pulsed while busy. The second `start` is ignored, and a `memRdValid` arriving outside WAITRD causes no write.

Source files
------------

// File: rtl/filter_buffer_ctrl.sv
// filter_buffer_ctrl
// Sequencer for the CNN filter buffer: loads four 32-bit filter words from
// filter memory into the 128-bit buffer, then replays the 16 filter bytes
// once per convolution window to the MAC, honouring per-byte backpressure.
// Optional feature macro: FILTER_STALL_CNT_EN adds a saturating 16-bit
// stallCount output counting STREAM cycles with macReady low.
module filter_buffer_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WIN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] filtBaseAddr,
    input  logic [WIN_W-1:0]  numWindows,
    output logic              memRdEn,
    output logic [ADDR_W-1:0] memRdAddr,
    input  logic [31:0]       memRdData,
    input  logic              memRdValid,
    output logic [31:0]       filterIn,
    output logic              WEFilter,
    output logic              REFilter,
    output logic              rstFilter,
    input  logic              macReady,
    output logic              byteValid,
    output logic              lastByte,
    output logic              windowDone,
    output logic              busy,
    output logic              done
`ifdef FILTER_STALL_CNT_EN
    ,
    output logic [15:0]       stallCount
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAITRD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_ARM    = 3'd4;
    localparam logic [2:0] S_STREAM = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [WIN_W-1:0]  numWin_q,    numWin_d;
    logic [WIN_W-1:0]  winCnt_q,    winCnt_d;
    logic [1:0]        wordCnt_q,   wordCnt_d;
    logic [3:0]        byteCnt_q,   byteCnt_d;
    logic [31:0]       filterIn_q,  filterIn_d;
    logic              byteValid_q, byteValid_d;
    logic              lastByte_q,  lastByte_d;
    logic              readEn;
    logic [WIN_W-1:0]  winCntInc;

    // Byte read strobe: MAC readiness only matters while streaming
    always_comb begin
        readEn    = (state_q == S_STREAM) && macReady;
        winCntInc = winCnt_q + WIN_W'(1);
    end

    // Next-state and counter update for the load/stream sequence
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        numWin_d   = numWin_q;
        winCnt_d   = winCnt_q;
        wordCnt_d  = wordCnt_q;
        byteCnt_d  = byteCnt_q;
        filterIn_d = filterIn_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    base_d    = filtBaseAddr;
                    numWin_d  = numWindows;
                    wordCnt_d = 2'd0;
                    winCnt_d  = '0;
                end
            end
            S_FETCH: begin
                state_d = S_WAITRD;
            end
            S_WAITRD: begin
                if (memRdValid) begin
                    filterIn_d = memRdData;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                // Load completion is tracked purely by our own word count
                if (wordCnt_q == 2'd3) begin
                    state_d = (numWin_q == '0) ? S_DONE : S_ARM;
                end else begin
                    wordCnt_d = wordCnt_q + 2'd1;
                    state_d   = S_FETCH;
                end
            end
            S_ARM: begin
                byteCnt_d = 4'd0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (readEn) begin
                    byteCnt_d = byteCnt_q + 4'd1;
                    if (byteCnt_q == 4'd15) begin
                        winCnt_d = winCntInc;
                        state_d  = (winCntInc == numWin_q) ? S_DONE : S_ARM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The buffer output is registered, so byte qualifiers trail the read strobe
    always_comb begin
        byteValid_d = readEn;
        lastByte_d  = readEn && (byteCnt_q == 4'd15);
    end

    // State and datapath registers; everything returns to zero on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            numWin_q    <= '0;
            winCnt_q    <= '0;
            wordCnt_q   <= 2'd0;
            byteCnt_q   <= 4'd0;
            filterIn_q  <= 32'd0;
            byteValid_q <= 1'b0;
            lastByte_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            numWin_q    <= numWin_d;
            winCnt_q    <= winCnt_d;
            wordCnt_q   <= wordCnt_d;
            byteCnt_q   <= byteCnt_d;
            filterIn_q  <= filterIn_d;
            byteValid_q <= byteValid_d;
            lastByte_q  <= lastByte_d;
        end
    end

    // Moore decode of memory and buffer strobes; the three buffer strobes
    // come from distinct states so they can never overlap
    always_comb begin
        memRdEn    = (state_q == S_FETCH);
        memRdAddr  = (state_q == S_FETCH) ? (base_q + ADDR_W'(wordCnt_q)) : '0;
        filterIn   = filterIn_q;
        WEFilter   = (state_q == S_WRITE);
        REFilter   = readEn;
        rstFilter  = (state_q == S_ARM);
        byteValid  = byteValid_q;
        lastByte   = lastByte_q;
        windowDone = lastByte_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

`ifdef FILTER_STALL_CNT_EN
    logic [15:0] stallCnt_q, stallCnt_d;

    // Saturating count of STREAM cycles lost to MAC backpressure
    always_comb begin
        stallCnt_d = stallCnt_q;
        if ((state_q == S_IDLE) && start) begin
            stallCnt_d = 16'd0;
        end else if ((state_q == S_STREAM) && !macReady && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= 16'd0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stallCount = stallCnt_q;
`endif

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// Scoreboard bench for filter_buffer_ctrl: the job model pushes expected reads,
// buffer writes, streamed bytes and done timing into queues; a monitor pops
// and compares whenever the DUT presents the corresponding event.
`timescale 1ns/1ps
module tb_filter_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  filtBaseAddr;
    logic [7:0]  numWindows;
    logic        memRdEn;
    logic [7:0]  memRdAddr;
    logic [31:0] memRdData;
    logic        memRdValid;
    logic [31:0] filterIn;
    logic        WEFilter;
    logic        REFilter;
    logic        rstFilter;
    logic        macReady;
    logic        byteValid;
    logic        lastByte;
    logic        windowDone;
    logic        busy;
    logic        done;
`ifdef FILTER_STALL_CNT_EN
    logic [15:0] stallCount;
`endif

    filter_buffer_ctrl #(.ADDR_W(8), .WIN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filtBaseAddr(filtBaseAddr), .numWindows(numWindows),
        .memRdEn(memRdEn), .memRdAddr(memRdAddr),
        .memRdData(memRdData), .memRdValid(memRdValid),
        .filterIn(filterIn), .WEFilter(WEFilter), .REFilter(REFilter),
        .rstFilter(rstFilter), .macReady(macReady),
        .byteValid(byteValid), .lastByte(lastByte), .windowDone(windowDone),
        .busy(busy), .done(done)
`ifdef FILTER_STALL_CNT_EN
        , .stallCount(stallCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct { int due; logic [7:0] addr; } req_t;
    logic [31:0] mem [256];
    int          mem_lat = 1;
    bit          inj_req = 1'b0;
    req_t        rq[$];

    initial begin
        memRdValid = 1'b0;
        memRdData  = 32'd0;
        forever begin
            @(posedge clk); #1;
            memRdValid = 1'b0;
            memRdData  = 32'hDEAD_BEEF;
            if (rst) begin
                rq.delete();
            end else begin
                if (memRdEn) begin
                    req_t r;
                    r.due  = cyc + mem_lat;
                    r.addr = memRdAddr;
                    rq.push_back(r);
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    memRdValid = 1'b1;
                    memRdData  = mem[rq[0].addr];
                    void'(rq.pop_front());
                end else if (inj_req) begin
                    memRdValid = 1'b1;
                    memRdData  = $urandom;
                    inj_req    = 1'b0;
                end
            end
        end
    end

    // ---------------- external filter buffer model ----------------
    logic [127:0] fbuf;
    logic [3:0]   fptr;
    logic [7:0]   fout;
    always @(posedge clk) begin
        if (WEFilter) fbuf <= {fbuf[95:0], filterIn};
        if (rstFilter) fptr <= 4'd0;
        else if (REFilter) begin
            fout <= fbuf[127 - 8*int'(fptr) -: 8];
            fptr <= fptr + 4'd1;
        end
    end

    // ---------------- MAC readiness driver ----------------
    int rdy_mode   = 0;
    int stall_left = 0;
    int rf_cnt     = 0;
    initial begin
        macReady = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: macReady = 1'b1;
                1: macReady = ($urandom_range(0, 3) != 0);
                default: begin
                    if (rf_cnt >= 8 && stall_left > 0) begin
                        macReady = 1'b0;
                        stall_left--;
                    end else begin
                        macReady = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [7:0] b; logic last; } byte_t;
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_wr_q[$];
    byte_t       exp_byte_q[$];
    int          exp_done_q[$];
    int          wd_cnt   = 0;
    int          arm_cnt  = 0;
    int          done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (memRdEn) begin
                if (exp_addr_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
                else check("rd_addr", 64'(memRdAddr), 64'(exp_addr_q.pop_front()));
            end
            if (WEFilter) begin
                if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
                else check("wr_data", 64'(filterIn), 64'(exp_wr_q.pop_front()));
            end
            if (WEFilter || REFilter || rstFilter)
                check("strobe_excl", 64'(int'(WEFilter) + int'(REFilter) + int'(rstFilter)), 64'(1));
            if (rstFilter) begin
                arm_cnt++;
                check("arm_boundary", 64'(rf_cnt % 16), 64'(0));
            end
            if (REFilter) rf_cnt++;
            if (byteValid) begin
                if (exp_byte_q.size() == 0) check("byte_unexpected", 64'(1), 64'(0));
                else begin
                    byte_t e;
                    e = exp_byte_q.pop_front();
                    check("byte", 64'({lastByte, fout}), 64'({e.last, e.b}));
                end
            end else if (lastByte) begin
                check("last_without_valid", 64'(1), 64'(0));
            end
            if (windowDone || lastByte) check("window_done", 64'(windowDone), 64'(lastByte));
            if (windowDone) wd_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_at_done", 64'(busy), 64'(1));
                if (exp_done_q.size() == 0) check("done_unexpected", 64'(1), 64'(0));
                else begin
                    int ec;
                    ec = exp_done_q.pop_front();
                    if (ec >= 0) check("done_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    // ---------------- job model and sequencing ----------------
    task automatic clear_queues();
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_byte_q.delete();
        exp_done_q.delete();
    endtask

    task automatic launch_job(input logic [7:0] base, input logic [7:0] n,
                              input int lat, input int mode, input bit chk_lat);
        logic [7:0] a;
        mem_lat = lat;
        rdy_mode = mode;
        stall_left = (mode == 2) ? 5 : 0;
        rf_cnt = 0;
        wd_cnt = 0;
        arm_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            a = base + 8'(k);
            exp_addr_q.push_back(a);
            exp_wr_q.push_back(mem[a]);
        end
        for (int w = 0; w < int'(n); w++) begin
            for (int k = 0; k < 16; k++) begin
                byte_t e;
                a = base + 8'(k / 4);
                e.b = 8'(mem[a] >> (24 - 8 * (k % 4)));
                e.last = (k == 15);
                exp_byte_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        filtBaseAddr = base;
        numWindows = n;
        start = 1'b1;
        exp_done_q.push_back(chk_lat ? cyc + 13 + 17 * int'(n) : -1);
    endtask

    task automatic finish_job(input logic [7:0] base, input logic [7:0] n,
                              input bit bstart, input bit inj);
        int d0;
        bit injd;
        d0 = done_cnt;
        injd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (bstart && i == 5) begin
                start = 1'b1;
                filtBaseAddr = base ^ 8'h55;
                numWindows = n + 8'd1;
            end
            if (inj && !injd && rf_cnt >= 3) begin
                inj_req = 1'b1;
                injd = 1'b1;
            end
            if (done_cnt != d0) break;
        end
        start = 1'b0;
        if (done_cnt == d0) check("done_timeout", 64'(0), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("single_done", 64'(done_cnt), 64'(d0 + 1));
        check("reads_left", 64'(exp_addr_q.size()), 64'(0));
        check("writes_left", 64'(exp_wr_q.size()), 64'(0));
        check("bytes_left", 64'(exp_byte_q.size()), 64'(0));
        check("window_pulses", 64'(wd_cnt), 64'(n));
        check("arm_pulses", 64'(arm_cnt), 64'(n));
        check("idle_after_job", 64'(busy), 64'(0));
        clear_queues();
    endtask

    task automatic run_job(input logic [7:0] base, input logic [7:0] n, input int lat,
                           input int mode, input bit chk_lat, input bit bstart, input bit inj);
        launch_job(base, n, lat, mode, chk_lat);
        finish_job(base, n, bstart, inj);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({memRdEn, memRdAddr, filterIn, WEFilter, REFilter, rstFilter,
                    byteValid, lastByte, windowDone, busy, done});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        filtBaseAddr = 8'd0;
        numWindows = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 64'(0));
`ifdef FILTER_STALL_CNT_EN
        check("reset_stallcount", 64'(stallCount), 64'(0));
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", out_vec(), 64'(0));

        // Base load, single window
        mem[8'h10] = 32'hA1A2A3A4;
        mem[8'h11] = 32'hB1B2B3B4;
        mem[8'h12] = 32'hC1C2C3C4;
        mem[8'h13] = 32'hD1D2D3D4;
        run_job(8'h10, 8'd1, 1, 0, 1'b1, 1'b0, 1'b0);

        // Multi-window
        run_job(8'h10, 8'd3, 1, 0, 1'b1, 1'b0, 1'b0);

        // Backpressure: five low cycles after byte 7
        run_job(8'h10, 8'd1, 1, 2, 1'b0, 1'b0, 1'b0);
`ifdef FILTER_STALL_CNT_EN
        check("stall_count", 64'(stallCount), 64'(5));
`endif

        // Zero windows: load only
        run_job(8'h40, 8'd0, 1, 0, 1'b1, 1'b0, 1'b0);

        // Address wrap
        run_job(8'hFE, 8'd1, 1, 0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of streaming, then a full reload
        launch_job(8'h20, 8'd2, 1, 0, 1'b0);
        for (int i = 0; i < 200 && rf_cnt < 9; i++) @(posedge clk);
        check("reached_byte9", 64'(rf_cnt >= 9), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", out_vec(), 64'(0));
`ifdef FILTER_STALL_CNT_EN
        check("async_reset_stallcount", 64'(stallCount), 64'(0));
`endif
        @(posedge clk); #1;
        start = 1'b0;
        clear_queues();
        rst = 1'b0;
        run_job(8'h20, 8'd2, 1, 0, 1'b1, 1'b0, 1'b0);

        // Slow memory, start while busy, stray read-valid while streaming
        run_job(8'h30, 8'd2, 3, 0, 1'b0, 1'b1, 1'b1);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            logic [7:0] b;
            logic [7:0] n;
            int lat;
            int mode;
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            b = 8'($urandom);
            n = 8'($urandom_range(0, 3));
            lat = $urandom_range(1, 4);
            mode = $urandom_range(0, 1);
            run_job(b, n, lat, mode, (lat == 1 && mode == 0), $urandom_range(0, 1) == 1,
                    (n != 0) && ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
